// File: rtl/music_snapshot_feeder.sv
// Captures 4-channel I/Q ADC snapshots into a frame buffer and replays
// each frame as one contiguous valid burst into the MUSIC core.
module music_snapshot_feeder #(
    parameter int N           = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int SAMPLES_NUM = 128,
    parameter int LEAD_CYCLES = 16
) (
    input  logic                         iclk,
    input  logic                         irst_n,
    input  logic                         icapture_en,
    input  logic                         iadc_valid,
    input  logic signed [DATA_WIDTH-1:0] iadc_i0,
    input  logic signed [DATA_WIDTH-1:0] iadc_q0,
    input  logic signed [DATA_WIDTH-1:0] iadc_i1,
    input  logic signed [DATA_WIDTH-1:0] iadc_q1,
    input  logic signed [DATA_WIDTH-1:0] iadc_i2,
    input  logic signed [DATA_WIDTH-1:0] iadc_q2,
    input  logic signed [DATA_WIDTH-1:0] iadc_i3,
    input  logic signed [DATA_WIDTH-1:0] iadc_q3,
    input  logic                         idoa_search_done,
    output logic                         odata_valid,
    output logic signed [DATA_WIDTH-1:0] odata_i0,
    output logic signed [DATA_WIDTH-1:0] odata_q0,
    output logic signed [DATA_WIDTH-1:0] odata_i1,
    output logic signed [DATA_WIDTH-1:0] odata_q1,
    output logic signed [DATA_WIDTH-1:0] odata_i2,
    output logic signed [DATA_WIDTH-1:0] odata_q2,
    output logic signed [DATA_WIDTH-1:0] odata_i3,
    output logic signed [DATA_WIDTH-1:0] odata_q3,
    output logic                         oframe_start,
    output logic [15:0]                  oframe_cnt,
    output logic [15:0]                  odrop_cnt,
    output logic                         obusy
);

    localparam int AW = $clog2(SAMPLES_NUM);
    localparam int LW = $clog2(LEAD_CYCLES) + 1;
    localparam int BW = 2 * N * DATA_WIDTH;

    typedef enum logic [1:0] {FILL, WAIT, LEAD, PLAY} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [BW-1:0] mem [SAMPLES_NUM];
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] lead_cnt;
    logic          first_frame;
    logic          done_pending;
    logic          rd_done;
    logic          last_q;
    logic          wr_en;
    logic          wr_last;
    logic          rd_en;
    logic          rd_last;
    logic          release_frame;
    logic          drop;

    assign wdata = {iadc_i0, iadc_q0, iadc_i1, iadc_q1,
                    iadc_i2, iadc_q2, iadc_i3, iadc_q3};
    assign {odata_i0, odata_q0, odata_i1, odata_q1,
            odata_i2, odata_q2, odata_i3, odata_q3} = rdata;

    assign wr_en   = (state == FILL) && iadc_valid && icapture_en;
    assign wr_last = wr_en && (wr_ptr == AW'(SAMPLES_NUM - 1));
    assign rd_en   = (state == PLAY) && !rd_done;
    assign rd_last = rd_en && (rd_ptr == AW'(SAMPLES_NUM - 1));
    assign drop    = iadc_valid && (state != FILL);
    assign obusy   = (state == LEAD) || (state == PLAY);

    // A done pulse arriving in WAIT releases the frame on its own
    assign release_frame = (state == WAIT) &&
                           (first_frame || done_pending || idoa_search_done);

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: if (wr_last) state_nxt = WAIT;
            WAIT: if (release_frame) state_nxt = LEAD;
            LEAD: if (lead_cnt == LW'(LEAD_CYCLES - 2)) state_nxt = PLAY;
            PLAY: if (last_q) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state        <= FILL;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lead_cnt     <= '0;
            first_frame  <= 1'b1;
            done_pending <= 1'b0;
            rd_done      <= 1'b0;
            last_q       <= 1'b0;
            rdata        <= '0;
            odata_valid  <= 1'b0;
            oframe_start <= 1'b0;
            oframe_cnt   <= '0;
            odrop_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            odata_valid  <= rd_en;
            oframe_start <= rd_en && (rd_ptr == '0);
            last_q       <= rd_last;
            lead_cnt     <= (state == LEAD) ? lead_cnt + 1'b1 : '0;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                rdata  <= mem[rd_ptr];
            end
            if (rd_last) begin
                rd_done    <= 1'b1;
                oframe_cnt <= oframe_cnt + 1'b1;
            end else if (state != PLAY) begin
                rd_done <= 1'b0;
            end
            // Clear wins: the pulse that releases the frame is consumed by it
            if (release_frame) begin
                first_frame  <= 1'b0;
                done_pending <= 1'b0;
            end else if (idoa_search_done &&
                         (state == FILL || state == WAIT)) begin
                done_pending <= 1'b1;
            end
            if (drop && odrop_cnt != 16'hFFFF) odrop_cnt <= odrop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_music_snapshot_feeder.sv
// Directed bench for music_snapshot_feeder: captured snapshots go into a
// scoreboard queue and are compared as the replay burst emerges.
module tb_music_snapshot_feeder;

    localparam int DW = 16;
    localparam int SN = 128;
    localparam int LC = 16;

    logic          iclk = 1'b0;
    logic          irst_n = 1'b0;
    logic          icapture_en = 1'b0;
    logic          iadc_valid = 1'b0;
    logic          idoa_search_done = 1'b0;
    logic [DW-1:0] iadc_i0, iadc_q0, iadc_i1, iadc_q1;
    logic [DW-1:0] iadc_i2, iadc_q2, iadc_i3, iadc_q3;
    logic          odata_valid;
    logic [DW-1:0] odata_i0, odata_q0, odata_i1, odata_q1;
    logic [DW-1:0] odata_i2, odata_q2, odata_i3, odata_q3;
    logic          oframe_start;
    logic [15:0]   oframe_cnt;
    logic [15:0]   odrop_cnt;
    logic          obusy;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [127:0]  sb[$];
    logic [127:0]  last_beat = '0;
    logic [127:0]  obeat;
    int            beat = 0;
    int            frames = 0;
    int            drops_exp = 0;

    music_snapshot_feeder #(
        .N(4), .DATA_WIDTH(DW), .SAMPLES_NUM(SN), .LEAD_CYCLES(LC)
    ) dut (
        .iclk(iclk), .irst_n(irst_n),
        .icapture_en(icapture_en), .iadc_valid(iadc_valid),
        .iadc_i0(iadc_i0), .iadc_q0(iadc_q0),
        .iadc_i1(iadc_i1), .iadc_q1(iadc_q1),
        .iadc_i2(iadc_i2), .iadc_q2(iadc_q2),
        .iadc_i3(iadc_i3), .iadc_q3(iadc_q3),
        .idoa_search_done(idoa_search_done),
        .odata_valid(odata_valid),
        .odata_i0(odata_i0), .odata_q0(odata_q0),
        .odata_i1(odata_i1), .odata_q1(odata_q1),
        .odata_i2(odata_i2), .odata_q2(odata_q2),
        .odata_i3(odata_i3), .odata_q3(odata_q3),
        .oframe_start(oframe_start), .oframe_cnt(oframe_cnt),
        .odrop_cnt(odrop_cnt), .obusy(obusy)
    );

    always #5 iclk = ~iclk;

    assign obeat = {odata_i0, odata_q0, odata_i1, odata_q1,
                    odata_i2, odata_q2, odata_i3, odata_q3};

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Burst monitor: order, contiguity, frame markers, hold value
    always @(negedge iclk) begin
        if (irst_n) begin
            if (odata_valid) begin
                logic [127:0] e;
                chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
                e = (sb.size() != 0) ? sb.pop_front() : '0;
                chk("beat_data", obeat, e);
                chk("frame_start", 128'(oframe_start), 128'(beat == 0));
                last_beat = e;
                if (beat == SN - 1) begin
                    frames++;
                    chk("frame_cnt", 128'(oframe_cnt), 128'(frames));
                end
                beat = (beat + 1) % SN;
            end else begin
                if (beat != 0) chk("burst_gap", 128'(odata_valid), 128'(1));
                chk("start_idle", 128'(oframe_start), 128'(0));
                chk("hold_data", obeat, last_beat);
            end
        end
    end

    task automatic drive(input logic v, input logic en,
                         input logic [15:0] i0v, input logic acc);
        logic [127:0] b;
        b = {$urandom(), $urandom(), $urandom(), $urandom()};
        b[127:112] = i0v;
        {iadc_i0, iadc_q0, iadc_i1, iadc_q1,
         iadc_i2, iadc_q2, iadc_i3, iadc_q3} = b;
        iadc_valid = v;
        icapture_en = en;
        if (v && en && acc) sb.push_back(b);
        @(posedge iclk);
        #2;
        iadc_valid = 1'b0;
        idoa_search_done = 1'b0;
    endtask

    task automatic fill(input int base, input int cnt, input int done_at);
        for (int k = 0; k < cnt; k++) begin
            idoa_search_done = (k == done_at);
            drive(1'b1, 1'b1, 16'(base + k), 1'b1);
        end
    endtask

    task automatic pulse_done();
        idoa_search_done = 1'b1;
        @(posedge iclk);
        #2;
        idoa_search_done = 1'b0;
    endtask

    task automatic lat_busy(input string tag, input int exp);
        int n = 0;
        while (!obusy && n < 50) begin
            @(posedge iclk);
            #2;
            n++;
        end
        chk(tag, 128'(n), 128'(exp));
    endtask

    task automatic lat_valid(input string tag);
        int n = 0;
        while (!odata_valid && n < 50) begin
            @(posedge iclk);
            #2;
            n++;
        end
        chk(tag, 128'(n), 128'(LC));
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (obusy && n < 400) begin
            @(posedge iclk);
            #2;
            n++;
        end
        chk(tag, 128'(obusy), 128'(0));
    endtask

    task automatic hold_idle(input string tag, input int cyc);
        int seen = 0;
        for (int k = 0; k < cyc; k++) begin
            @(posedge iclk);
            #2;
            if (obusy || odata_valid) seen++;
        end
        chk(tag, 128'(seen), 128'(0));
    endtask

    initial begin
        int acc;
        int j;
        int n;
        logic v;
        logic en;

        repeat (3) @(posedge iclk);
        #2;
        chk("rst_valid", 128'(odata_valid), 128'(0));
        chk("rst_busy", 128'(obusy), 128'(0));
        chk("rst_data", obeat, 128'(0));
        chk("rst_fcnt", 128'(oframe_cnt), 128'(0));
        chk("rst_dcnt", 128'(odrop_cnt), 128'(0));
        irst_n = 1'b1;
        @(posedge iclk);
        #2;

        // 1: first frame released without a done pulse
        fill(0, SN, -1);
        lat_busy("t1_lead_entry", 1);
        lat_valid("t1_lead_lat");
        wait_end("t1_end");
        chk("t1_fcnt", 128'(oframe_cnt), 128'(1));

        // 2: second frame waits for the done pulse
        fill(200, SN, -1);
        hold_idle("t2_wait_hold", 1000);
        pulse_done();
        lat_busy("t2_release", 0);
        lat_valid("t2_lead_lat");
        wait_end("t2_end");
        chk("t2_fcnt", 128'(oframe_cnt), 128'(2));

        // 3: done during FILL releases at once; done during PLAY is stale
        fill(400, SN, 40);
        lat_busy("t3_release", 1);
        lat_valid("t3_lead_lat");
        repeat (20) @(posedge iclk);
        #2;
        pulse_done();
        wait_end("t3_end");
        chk("t3_fcnt", 128'(oframe_cnt), 128'(3));

        // 4: sparse strobes with capture enable toggling
        acc = 0;
        j = 0;
        while (acc < SN) begin
            v = (j % 3 == 0);
            en = ((j / 5) % 2 == 0);
            drive(v, en, 16'(1000 + acc), 1'b1);
            if (v && en) acc++;
            j++;
        end
        chk("t4_drops", 128'(odrop_cnt), 128'(drops_exp));
        hold_idle("t3_stale_done", 200);
        pulse_done();
        lat_busy("t4_release", 0);
        lat_valid("t4_lead_lat");
        wait_end("t4_end");
        chk("t4_fcnt", 128'(oframe_cnt), 128'(4));

        // 5: strobe held through WAIT+LEAD+PLAY (1+15+129 cycles)
        fill(2000, SN - 1, 10);
        for (int k = 0; k < 146; k++)
            drive(1'b1, 1'b1, 16'(2000 + SN - 1), 1'(k == 0));
        drops_exp += 145;
        chk("t5_drops", 128'(odrop_cnt), 128'(drops_exp));
        chk("t5_back_fill", 128'(obusy), 128'(0));
        chk("t5_fcnt", 128'(oframe_cnt), 128'(5));

        fill(3000, SN, -1);
        iadc_valid = 1'b1;
        repeat (65400) @(posedge iclk);
        #2;
        iadc_valid = 1'b0;
        drops_exp = (drops_exp + 65400 > 65535) ? 65535 : drops_exp + 65400;
        chk("t5_still_wait", 128'(obusy), 128'(0));
        chk("t5_saturate", 128'(odrop_cnt), 128'(drops_exp));
        pulse_done();
        lat_busy("t5_release", 0);
        lat_valid("t5_lead_lat");
        wait_end("t5_end");
        chk("t5_sat_hold", 128'(odrop_cnt), 128'(16'hFFFF));

        // 6: reset in the middle of a burst
        fill(4000, SN, 0);
        lat_busy("t6_release", 1);
        n = 0;
        while (beat < 60 && n < 300) begin
            @(posedge iclk);
            #2;
            n++;
        end
        chk("t6_reach_beat60", 128'(beat), 128'(60));
        irst_n = 1'b0;
        #1;
        chk("t6_valid_async", 128'(odata_valid), 128'(0));
        chk("t6_busy_async", 128'(obusy), 128'(0));
        chk("t6_fcnt_rst", 128'(oframe_cnt), 128'(0));
        chk("t6_dcnt_rst", 128'(odrop_cnt), 128'(0));
        sb.delete();
        beat = 0;
        frames = 0;
        last_beat = '0;
        @(posedge iclk);
        #2;
        irst_n = 1'b1;
        @(posedge iclk);
        #2;
        fill(5000, SN, -1);
        lat_busy("t6_first_again", 1);
        lat_valid("t6_lead_lat");
        wait_end("t6_end");
        chk("t6_fcnt", 128'(oframe_cnt), 128'(1));
        chk("t6_sb_drained", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
